regfile_dump: RTL

REGFILE_DUMP -- requirements
Module: regfile_dump

---
 rtl/regfile_dump.sv | 116 +++++++++++
 1 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: streams r0..LAST_REG from a register file read port over a valid/ready link; optional XOR checksum word via REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump #(
    parameter int LAST_REG = 31
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    output logic [4:0]  rn,
    input  logic [31:0] q,
    output logic [31:0] dout,
    output logic        dvalid,
    input  logic        dready,
    output logic        dlast,
    output logic        busy,
    output logic        done
);
`ifdef REGFILE_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, READ, SEND, DONE} state_t;
`endif
    localparam logic [4:0] LAST = 5'(LAST_REG);
    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] dout_q, dout_d;
    logic        dvalid_q, dvalid_d;
    logic        dlast_q, dlast_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif
    assign rn     = idx_q;
    assign dout   = dout_q;
    assign dvalid = dvalid_q;
    assign dlast  = dlast_q;
    assign busy   = state_q != IDLE;
    assign done   = state_q == DONE;
    // next-state: one read cycle then hold the word until the consumer takes it
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        dlast_d  = dlast_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                idx_d   = 5'd0;
                state_d = READ;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                csum_d  = 32'd0;
`endif
            end
            READ: begin
                dout_d   = q;
                dvalid_d = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                dlast_d  = 1'b0;
                csum_d   = csum_q ^ q;
`else
                dlast_d  = idx_q == LAST;
`endif
                state_d  = SEND;
            end
            SEND: if (dvalid_q && dready) begin
                dvalid_d = 1'b0;
                dlast_d  = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                state_d  = (idx_q == LAST) ? CSUM : READ;
`else
                state_d  = (idx_q == LAST) ? DONE : READ;
`endif
                idx_d    = (idx_q == LAST) ? idx_q : idx_q + 5'd1;
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            CSUM: if (!dvalid_q) begin
                dout_d   = csum_q;
                dvalid_d = 1'b1;
                dlast_d  = 1'b1;
            end else if (dready) begin
                dvalid_d = 1'b0;
                dlast_d  = 1'b0;
                state_d  = DONE;
            end
`endif
            DONE: begin
                idx_d   = 5'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // state and output registers; reset aborts any dump in progress
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= IDLE;
            idx_q    <= 5'd0;
            dout_q   <= 32'd0;
            dvalid_q <= 1'b0;
            dlast_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_q   <= 32'd0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            dlast_q  <= dlast_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end
endmodule
